// File: rtl/fifo_rr_scheduler_if.sv
// Handshake bundle between fifo_rr_scheduler and its source fifos / downstream consumer.
// master: the scheduler side. slave: the environment (source fifos plus consumer).
interface fifo_rr_scheduler_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned SRC_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_empty;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_pop;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [SRC_WIDTH-1:0]          out_src;

  modport master (
    input  req_empty, req_data, out_ready,
    output req_pop, out_valid, out_data, out_src
  );

  modport slave (
    output req_empty, req_data, out_ready,
    input  req_pop, out_valid, out_data, out_src
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler: pops one word at a time from NUM_REQ source fifos and presents
// it on a valid/ready port tagged with its source index. One word is outstanding at a time.
// Optional feature macro: FIFO_SCHED_BURST_EN (keep the grant for up to BURST_LEN pops).
module fifo_rr_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                clk,
  input  logic                rst,
  fifo_rr_scheduler_if.master bus,
  output logic                busy
);
  localparam int unsigned SrcW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || BURST_LEN < 1) begin : gen_param_check
    $error("fifo_rr_scheduler: NUM_REQ must be >= 2 and BURST_LEN >= 1");
  end

  typedef enum logic [1:0] {StIdle, StPop, StCapt, StSend} state_e;

  state_e                state_q;
  logic [SrcW-1:0]       rr_ptr_q;
  logic [NUM_REQ-1:0]    req_pop_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SrcW-1:0]       out_src_q;

  logic                  grant_found;
  logic [SrcW-1:0]       grant_idx;
  logic [NUM_REQ-1:0]    grant_onehot;
  logic [NUM_REQ-1:0]    ptr_onehot;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  burst_ok;

`ifdef FIFO_SCHED_BURST_EN
  localparam int unsigned CntW = $clog2(BURST_LEN + 1);
  logic [CntW-1:0] burst_cnt_q;
`endif

  // Round-robin search starting just after the last grant; wraps at NUM_REQ-1.
  always_comb begin
    int unsigned idx;
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    ptr_onehot   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && !bus.req_empty[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx[SrcW-1:0];
      end
    end
    grant_onehot[grant_idx] = 1'b1;
    ptr_onehot[rr_ptr_q]    = 1'b1;
  end

  // Word from the currently granted fifo and burst continuation decision.
  always_comb begin
    sel_data = bus.req_data[32'(rr_ptr_q)*DATA_WIDTH +: DATA_WIDTH];
`ifdef FIFO_SCHED_BURST_EN
    burst_ok = !bus.req_empty[rr_ptr_q] && (32'(burst_cnt_q) < BURST_LEN - 1);
`else
    burst_ok = 1'b0;
`endif
  end

  // Scheduler FSM with registered pop and output-port state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= SrcW'(NUM_REQ - 1);
      req_pop_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
`ifdef FIFO_SCHED_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            req_pop_q <= grant_onehot;
            rr_ptr_q  <= grant_idx;
            state_q   <= StPop;
          end
        end
        StPop: begin
          // The fifo registers the popped word at this edge.
          req_pop_q <= '0;
          state_q   <= StCapt;
        end
        StCapt: begin
          out_data_q  <= sel_data;
          out_src_q   <= rr_ptr_q;
          out_valid_q <= 1'b1;
          state_q     <= StSend;
        end
        StSend: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (burst_ok) begin
              // Keep the grant: re-pop the same fifo, pointer unchanged.
              req_pop_q <= ptr_onehot;
              state_q   <= StPop;
`ifdef FIFO_SCHED_BURST_EN
              burst_cnt_q <= burst_cnt_q + 1'b1;
`endif
            end else begin
`ifdef FIFO_SCHED_BURST_EN
              burst_cnt_q <= '0;
`endif
              if (grant_found) begin
                req_pop_q <= grant_onehot;
                rr_ptr_q  <= grant_idx;
                state_q   <= StPop;
              end else begin
                state_q <= StIdle;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_pop   = req_pop_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler with behavioural source fifos and a scoreboard queue.
module tb_fifo_rr_scheduler;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned BL = 2;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  int total = 0;
  int bad   = 0;
  logic [SW+DW-1:0] exp_q[$];
  logic chk_rate = 1'b0;

  always #5 clk = ~clk;

  fifo_rr_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_rr_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master),
    .busy(busy)
  );

  // Source fifo models: registered data_out on pop, cleared by the shared reset.
  logic [DW-1:0] mem[NR][16];
  logic [3:0]    wr[NR];
  logic [3:0]    rd[NR];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NR; i++) begin
      if (rst) begin
        rd[i] <= wr[i];
      end else if (bus.req_pop[i] && rd[i] != wr[i]) begin
        bus.req_data[i*DW +: DW] <= mem[i][rd[i]];
        rd[i] <= rd[i] + 4'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) bus.req_empty[i] = (rd[i] == wr[i]);
  end

  // Output monitor: samples just before each posedge (inputs change at posedge+1).
  initial begin
    int cyc = 0;
    int pop_cyc = -100;
    int last_xfer = -1;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [SW-1:0] prev_src = '0;
    logic [SW+DW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus.req_pop != 0) pop_cyc = cyc;
        total++;
        assert ($onehot0(bus.req_pop) && !(bus.out_valid && bus.req_pop != 0)
                && (bus.req_pop & bus.req_empty) == 0)
        else begin
          bad++;
          $error("FAIL pop_rule got pop=%b empty=%b valid=%b want onehot0/non-empty/idle-port",
                 bus.req_pop, bus.req_empty, bus.out_valid);
        end
        if (bus.out_valid && !prev_valid) begin
          total++;
          assert (cyc - pop_cyc == 2)
          else begin
            bad++;
            $error("FAIL latency got=%0d want=2", cyc - pop_cyc);
          end
        end
        if (prev_valid && !prev_ready) begin
          total++;
          assert (bus.out_valid === 1'b1 && bus.out_data === prev_data && bus.out_src === prev_src)
          else begin
            bad++;
            $error("FAIL stall_hold got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                   bus.out_valid, bus.out_data, bus.out_src, prev_data, prev_src);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          total++;
          assert (exp_q.size() != 0)
          else begin
            bad++;
            $error("FAIL unexpected_word got src=%0d data=%h want none", bus.out_src, bus.out_data);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            assert ({bus.out_src, bus.out_data} === e)
            else begin
              bad++;
              $error("FAIL word got src=%0d data=%h want src=%0d data=%h",
                     bus.out_src, bus.out_data, e[SW+DW-1:DW], e[DW-1:0]);
            end
          end
          if (chk_rate && last_xfer >= 0) begin
            total++;
            assert (cyc - last_xfer == 3)
            else begin
              bad++;
              $error("FAIL rate got=%0d want=3", cyc - last_xfer);
            end
          end
          last_xfer = chk_rate ? cyc : -1;
        end
      end
      prev_valid = rst ? 1'b0 : bus.out_valid;
      prev_ready = bus.out_ready;
      prev_data  = bus.out_data;
      prev_src   = bus.out_src;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int f, input logic [DW-1:0] d);
    mem[f][wr[f]] = d;
    wr[f] = wr[f] + 4'd1;
  endtask

  task automatic load_exp(input int f, input logic [DW-1:0] d);
    logic [SW-1:0] s;
    s = f[SW-1:0];
    load(f, d);
    exp_q.push_back({s, d});
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    assert (bus.out_valid === 1'b0 && bus.req_pop === '0 && busy === 1'b0
            && bus.out_data === '0 && bus.out_src === '0)
    else begin
      bad++;
      $error("FAIL %s got v=%b pop=%b busy=%b d=%h s=%0d want all zero", tag,
             bus.out_valid, bus.req_pop, busy, bus.out_data, bus.out_src);
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    #1;
    check_reset_state("reset_state");
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      step();
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    total++;
    assert (done)
    else begin
      bad++;
      $error("FAIL %s got pending=%0d busy=%b want drained", tag, exp_q.size(), busy);
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < NR; i++) wr[i] = 4'd0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state("reset_initial");
    step();
    step();
    rst = 1'b0;

    // 1: all empty for 20 cycles, out_ready high has no effect.
    bus.out_ready = 1'b1;
    repeat (20) begin
      step();
      total++;
      assert ({bus.req_pop, bus.out_valid, busy} === '0)
      else begin
        bad++;
        $error("FAIL all_empty got pop=%b v=%b busy=%b want 0", bus.req_pop, bus.out_valid, busy);
      end
    end

    // 2: single fifo with two words.
    do_reset();
    load_exp(0, 8'h11);
    load_exp(0, 8'h22);
    wait_drain("single_src");

    // 3: all four fifos active, strict rotation at one word per three cycles.
    do_reset();
    chk_rate = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) load_exp(i, 8'hA0 + 8'(i));
    wait_drain("rotation");
    chk_rate = 1'b0;

    // 4: downstream stall for 10 cycles.
    do_reset();
    bus.out_ready = 1'b0;
    load_exp(2, 8'h5C);
    for (int n = 0; n < 20 && !bus.out_valid; n++) step();
    total++;
    assert (bus.out_valid === 1'b1)
    else begin
      bad++;
      $error("FAIL stall_valid got=%b want=1", bus.out_valid);
    end
    repeat (10) begin
      step();
      total++;
      assert (bus.req_pop === '0 && bus.out_valid === 1'b1 && bus.out_data === 8'h5C
              && bus.out_src === 2'd2)
      else begin
        bad++;
        $error("FAIL stall got pop=%b v=%b d=%h s=%0d want pop=0 v=1 d=5c s=2",
               bus.req_pop, bus.out_valid, bus.out_data, bus.out_src);
      end
    end
    bus.out_ready = 1'b1;
    step();
    total++;
    assert (bus.out_valid === 1'b0)
    else begin
      bad++;
      $error("FAIL stall_release got v=%b want=0", bus.out_valid);
    end
    wait_drain("stall");

    // 5: two fifos with three words each.
    do_reset();
    for (int w = 0; w < 3; w++) begin
      load(0, 8'h50 + 8'(w));
      load(1, 8'h60 + 8'(w));
    end
`ifdef FIFO_SCHED_BURST_EN
    exp_q.push_back({2'd0, 8'h50}); exp_q.push_back({2'd0, 8'h51});
    exp_q.push_back({2'd1, 8'h60}); exp_q.push_back({2'd1, 8'h61});
    exp_q.push_back({2'd0, 8'h52}); exp_q.push_back({2'd1, 8'h62});
`else
    exp_q.push_back({2'd0, 8'h50}); exp_q.push_back({2'd1, 8'h60});
    exp_q.push_back({2'd0, 8'h51}); exp_q.push_back({2'd1, 8'h61});
    exp_q.push_back({2'd0, 8'h52}); exp_q.push_back({2'd1, 8'h62});
`endif
    wait_drain("two_src");

    // 6: reset while a popped word is being captured; the word is dropped.
    do_reset();
    load(1, 8'h61);
    load(1, 8'h62);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      if (bus.req_pop === 4'b0010) seen = 1'b1;
    end
    total++;
    assert (seen)
    else begin
      bad++;
      $error("FAIL capt_grant got pop=%b want=0010", bus.req_pop);
    end
    step();
    rst = 1'b1;
    #1;
    check_reset_state("reset_in_capt");
    step();
    rst = 1'b0;
    load_exp(0, 8'h70);
    load_exp(3, 8'h73);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      if (bus.req_pop !== '0) seen = 1'b1;
    end
    total++;
    assert (bus.req_pop === 4'b0001)
    else begin
      bad++;
      $error("FAIL first_grant_after_reset got pop=%b want=0001", bus.req_pop);
    end
    wait_drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
